// File: rtl/dp_sched_pkg.sv
// Shared types and constants for the dot-product job scheduler.
// Descriptor layout is {out_addr, len, b_addr, a_addr} with a_addr in the LSBs.
package dp_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_F = 3'd1,
        S_WAIT_F  = 3'd2,
        S_ISSUE_C = 3'd3,
        S_WAIT_C  = 3'd4,
        S_ISSUE_W = 3'd5,
        S_WAIT_W  = 3'd6,
        S_CMPL    = 3'd7
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    localparam logic [1:0] PH_NONE    = 2'd0;
    localparam logic [1:0] PH_FETCH   = 2'd1;
    localparam logic [1:0] PH_COMPUTE = 2'd2;
    localparam logic [1:0] PH_STORE   = 2'd3;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LEN_W  = 32;

    // Field offsets depend on the instance widths, so they are functions.
    function automatic int desc_width(input int aw, input int lw);
        return 3 * aw + lw;
    endfunction

    function automatic int desc_a_lsb(input int aw);
        return 0 * aw;
    endfunction

    function automatic int desc_b_lsb(input int aw);
        return aw;
    endfunction

    function automatic int desc_len_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int desc_out_lsb(input int aw, input int lw);
        return 2 * aw + lw;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = i_req;
        if (i_req == 2'b11)
            w_grant = r_last_grant ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_grant <= 1'b1;
        else if (i_accept && (w_grant != 2'b00))
            r_last_grant <= w_grant[1];
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/dp_job_sched.sv
// Job scheduler: arbitrates two descriptor sources and sequences
// fetch -> compute -> store, reporting a completion code per job.
module dp_job_sched
    import dp_sched_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAX_LEN = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic                          req1_valid,
    output logic                          req0_ready,
    output logic                          req1_ready,
    input  logic [3*ADDR_W+LEN_W-1:0]     req0_desc,
    input  logic [3*ADDR_W+LEN_W-1:0]     req1_desc,
    output logic [ADDR_W-1:0]             vector_a_addr,
    output logic [ADDR_W-1:0]             vector_b_addr,
    output logic [ADDR_W-1:0]             output_addr,
    output logic [LEN_W-1:0]              vector_len,
    output logic                          start_fetch,
    output logic                          start_compute,
    output logic                          start_write,
    input  logic                          fetch_done,
    input  logic                          processing_done,
    input  logic                          store_done,
    output logic                          busy,
    output logic                          cmpl_valid,
    output logic                          cmpl_id,
    output logic [1:0]                    cmpl_err,
    output logic [1:0]                    cmpl_phase
);

    localparam int DESC_W  = desc_width(ADDR_W, LEN_W);
    localparam int A_LSB   = desc_a_lsb(ADDR_W);
    localparam int B_LSB   = desc_b_lsb(ADDR_W);
    localparam int LEN_LSB = desc_len_lsb(ADDR_W);
    localparam int OUT_LSB = desc_out_lsb(ADDR_W, LEN_W);
    localparam int CNT_W   = $clog2(TIMEOUT);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_a_addr;
    logic [ADDR_W-1:0]   r_b_addr;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [LEN_W-1:0]    r_len;
    logic                r_job_id;
    logic                r_cmpl_id;
    logic [1:0]          r_cmpl_err;
    logic [1:0]          r_cmpl_phase;
    logic [CNT_W-1:0]    r_cnt;

    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_accept;
    logic [DESC_W-1:0]   w_desc;
    logic [LEN_W-1:0]    w_len;
    logic                w_len_bad;
    logic                w_done;
    logic                w_tmo;
    logic [1:0]          w_phase;
    state_t              w_next;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_idle     = (r_state == S_IDLE);
    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];
    assign w_accept   = w_idle && (w_grant != 2'b00);

    assign w_desc    = w_grant[1] ? req1_desc : req0_desc;
    assign w_len     = w_desc[LEN_LSB +: LEN_W];
    assign w_len_bad = (w_len == '0) || (w_len > LEN_W'(MAX_LEN));

    // Only the done input of the phase being waited on is ever looked at.
    always_comb begin
        w_done  = 1'b0;
        w_phase = PH_NONE;
        w_next  = S_IDLE;
        case (r_state)
            S_WAIT_F: begin
                w_done  = fetch_done;
                w_phase = PH_FETCH;
                w_next  = S_ISSUE_C;
            end
            S_WAIT_C: begin
                w_done  = processing_done;
                w_phase = PH_COMPUTE;
                w_next  = S_ISSUE_W;
            end
            S_WAIT_W: begin
                w_done  = store_done;
                w_phase = PH_STORE;
                w_next  = S_CMPL;
            end
            default: ;
        endcase
    end

    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_a_addr     <= '0;
            r_b_addr     <= '0;
            r_out_addr   <= '0;
            r_len        <= '0;
            r_job_id     <= 1'b0;
            r_cmpl_id    <= 1'b0;
            r_cmpl_err   <= ERR_OK;
            r_cmpl_phase <= PH_NONE;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_addr   <= w_desc[A_LSB +: ADDR_W];
                        r_b_addr   <= w_desc[B_LSB +: ADDR_W];
                        r_out_addr <= w_desc[OUT_LSB +: ADDR_W];
                        r_len      <= w_len;
                        r_job_id   <= w_grant[1];
                        if (w_len_bad) begin
                            r_state      <= S_CMPL;
                            r_cmpl_id    <= w_grant[1];
                            r_cmpl_err   <= ERR_LEN;
                            r_cmpl_phase <= PH_NONE;
                        end else begin
                            r_state <= S_ISSUE_F;
                        end
                    end
                end
                S_ISSUE_F: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_F;
                end
                S_ISSUE_C: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_C;
                end
                S_ISSUE_W: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_W;
                end
                // A done arriving on the last counted cycle still wins over the abort.
                S_WAIT_F, S_WAIT_C, S_WAIT_W: begin
                    if (w_done) begin
                        r_state <= w_next;
                        if (r_state == S_WAIT_W) begin
                            r_cmpl_id    <= r_job_id;
                            r_cmpl_err   <= ERR_OK;
                            r_cmpl_phase <= PH_NONE;
                        end
                    end else if (w_tmo) begin
                        r_state      <= S_CMPL;
                        r_cmpl_id    <= r_job_id;
                        r_cmpl_err   <= ERR_TMO;
                        r_cmpl_phase <= w_phase;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CMPL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign start_fetch   = (r_state == S_ISSUE_F);
    assign start_compute = (r_state == S_ISSUE_C);
    assign start_write   = (r_state == S_ISSUE_W);
    assign busy          = !w_idle;
    assign cmpl_valid    = (r_state == S_CMPL);
    assign cmpl_id       = r_cmpl_id;
    assign cmpl_err      = r_cmpl_err;
    assign cmpl_phase    = r_cmpl_phase;

    assign vector_a_addr = r_a_addr;
    assign vector_b_addr = r_b_addr;
    assign output_addr   = r_out_addr;
    assign vector_len    = r_len;

endmodule

// File: tb/tb_dp_job_sched.sv
// Bench for dp_job_sched: queued requesters, a delay-driven datapath responder
// and a timeline model of each job computed from the scheduling rules.
module tb_dp_job_sched;

    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int ML  = 256;
    localparam int TMO = 16;
    localparam int DW  = 3 * AW + LW;

    typedef struct {
        logic [DW-1:0] desc;
        int            df;
        int            dc;
        int            dw;
        bit            stale;
    } job_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          r0v = 1'b0;
    logic          r1v = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] r0d = '0;
    logic [DW-1:0] r1d = '0;
    logic [AW-1:0] vector_a_addr, vector_b_addr, output_addr;
    logic [LW-1:0] vector_len;
    logic          start_fetch, start_compute, start_write;
    logic          fetch_done = 1'b0;
    logic          processing_done = 1'b0;
    logic          store_done = 1'b0;
    logic          busy, cmpl_valid, cmpl_id;
    logic [1:0]    cmpl_err, cmpl_phase;

    int            vectors = 0;
    int            miscompares = 0;

    job_t          q0[$];
    job_t          q1[$];
    bit            model_last = 1'b1;
    logic [DW-1:0] exp_desc = '0;
    logic [4:0]    exp_cmpl = '0;

    int cur_df = 1, cur_dc = 1, cur_dw = 1;
    bit cur_stale = 1'b0;
    int cf = 0, cc = 0, cw = 0;
    bit pf, pc, pw, pd_f = 1'b0, pd_c = 1'b0, pd_w = 1'b0;

    always #5 clk = ~clk;

    dp_job_sched #(.ADDR_W(AW), .LEN_W(LW), .MAX_LEN(ML), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req1_valid(r1v),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_desc(r0d), .req1_desc(r1d),
        .vector_a_addr(vector_a_addr), .vector_b_addr(vector_b_addr),
        .output_addr(output_addr), .vector_len(vector_len),
        .start_fetch(start_fetch), .start_compute(start_compute), .start_write(start_write),
        .fetch_done(fetch_done), .processing_done(processing_done), .store_done(store_done),
        .busy(busy), .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id),
        .cmpl_err(cmpl_err), .cmpl_phase(cmpl_phase)
    );

    // Datapath stand-in: done pulses d cycles after each start (d==0: never).
    // With stale set it also raises the phase's own done during the start cycle
    // and the two foreign dones on the first wait cycle.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            cf = 0; cc = 0; cw = 0;
            pd_f = 0; pd_c = 0; pd_w = 0;
            fetch_done = 0; processing_done = 0; store_done = 0;
        end else begin
            pf = 0; pc = 0; pw = 0;
            if (cf > 0) begin cf--; pf = (cf == 0); end
            if (cc > 0) begin cc--; pc = (cc == 0); end
            if (cw > 0) begin cw--; pw = (cw == 0); end
            if (start_fetch   && cur_df > 0) cf = cur_df;
            if (start_compute && cur_dc > 0) cc = cur_dc;
            if (start_write   && cur_dw > 0) cw = cur_dw;
            fetch_done      = pf | (cur_stale & (start_fetch   | pd_c | pd_w));
            processing_done = pc | (cur_stale & (start_compute | pd_f | pd_w));
            store_done      = pw | (cur_stale & (start_write   | pd_f | pd_c));
            pd_f = start_fetch; pd_c = start_compute; pd_w = start_write;
        end
    end

    function automatic logic [DW-1:0] mk(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                         input logic [LW-1:0] len, input logic [AW-1:0] o);
        return {o, len, b, a};
    endfunction

    function automatic job_t mkjob(input logic [DW-1:0] d, input int df, input int dc,
                                   input int dw, input bit st);
        job_t j;
        j.desc = d; j.df = df; j.dc = dc; j.dw = dw; j.stale = st;
        return j;
    endfunction

    // Job timeline relative to the accept cycle (0); -1 means "never happens".
    function automatic void model(input job_t j, output int err, output int ph,
                                  output int sf, output int sc, output int sw, output int tc);
        int     d[3];
        int     s[3];
        int     t;
        longint len;
        d = '{j.df, j.dc, j.dw};
        s = '{-1, -1, -1};
        len = j.desc[2*AW +: LW];
        err = 0; ph = 0; tc = -1;
        if (len == 0 || len > ML) begin
            err = 1; tc = 1;
        end else begin
            t = 1;
            for (int p = 0; p < 3; p++) begin
                if (err == 0) begin
                    s[p] = t;
                    if (d[p] == 0 || d[p] > TMO) begin
                        err = 2; ph = p + 1; tc = t + 1 + TMO;
                    end else begin
                        t = t + d[p] + 1;
                    end
                end
            end
            if (err == 0) tc = t;
        end
        sf = s[0]; sc = s[1]; sw = s[2];
    endfunction

    task automatic run_sched(input string nm, input int budget);
        bit         in_job, e_id;
        int         rel, n, g;
        int         e_err, e_ph, e_sf, e_sc, e_sw, e_tc;
        job_t       j;
        logic [4:0] ectl, octl, ocm;
        logic [1:0] erdy, ordy;
        in_job = 0; e_id = 0; rel = 0; n = 0; g = 0;
        e_err = 0; e_ph = 0; e_sf = -1; e_sc = -1; e_sw = -1; e_tc = -1;
        while ((q0.size() > 0 || q1.size() > 0 || in_job) && n < budget) begin
            @(posedge clk); #3; n++;
            if (in_job) rel++;
            r0v = (q0.size() > 0);
            if (r0v) r0d = q0[0].desc;
            r1v = (q1.size() > 0);
            if (r1v) r1d = q1[0].desc;
            #1;
            ectl = in_job ? {rel == e_sf, rel == e_sc, rel == e_sw, rel == e_tc, 1'b1} : 5'b0;
            if (in_job && rel == e_tc) exp_cmpl = {e_id, 2'(e_err), 2'(e_ph)};
            octl = {start_fetch, start_compute, start_write, cmpl_valid, busy};
            vectors++;
            if (octl !== ectl) begin
                miscompares++;
                $display("FAIL %s ctl rel=%0d: got sf/sc/sw/cv/busy=%b want %b", nm, rel, octl, ectl);
            end
            ocm = {cmpl_id, cmpl_err, cmpl_phase};
            vectors++;
            if (ocm !== exp_cmpl) begin
                miscompares++;
                $display("FAIL %s cmpl rel=%0d: got id/err/ph=%b want %b", nm, rel, ocm, exp_cmpl);
            end
            vectors++;
            if ({output_addr, vector_len, vector_b_addr, vector_a_addr} !== exp_desc) begin
                miscompares++;
                $display("FAIL %s addr rel=%0d: got %h want %h", nm, rel,
                         {output_addr, vector_len, vector_b_addr, vector_a_addr}, exp_desc);
            end
            erdy = 2'b00;
            if (!in_job && (r0v || r1v)) begin
                g = (r0v && r1v) ? (model_last ? 0 : 1) : (r1v ? 1 : 0);
                erdy = (g == 1) ? 2'b10 : 2'b01;
            end
            ordy = {req1_ready, req0_ready};
            vectors++;
            if (ordy !== erdy) begin
                miscompares++;
                $display("FAIL %s ready rel=%0d: got %b want %b", nm, rel, ordy, erdy);
            end
            if (in_job) begin
                if (rel == e_tc) in_job = 0;
            end else if (erdy != 2'b00) begin
                if (g == 1) j = q1.pop_front();
                else        j = q0.pop_front();
                model(j, e_err, e_ph, e_sf, e_sc, e_sw, e_tc);
                e_id = (g == 1);
                model_last = (g == 1);
                exp_desc = j.desc;
                cur_df = j.df; cur_dc = j.dc; cur_dw = j.dw; cur_stale = j.stale;
                in_job = 1; rel = 0;
            end
        end
        if (in_job || q0.size() > 0 || q1.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL %s budget: got %0d jobs pending after %0d cycles want 0",
                     nm, q0.size() + q1.size() + int'(in_job), n);
            q0.delete(); q1.delete();
        end
        r0v = 0; r1v = 0;
    endtask

    task automatic check_reset_outputs(input string nm);
        vectors++;
        if ({start_fetch, start_compute, start_write, cmpl_valid, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL %s ctl: got %b want 00000", nm,
                     {start_fetch, start_compute, start_write, cmpl_valid, busy});
        end
        vectors++;
        if ({cmpl_id, cmpl_err, cmpl_phase} !== 5'b0) begin
            miscompares++;
            $display("FAIL %s cmpl: got %b want 00000", nm, {cmpl_id, cmpl_err, cmpl_phase});
        end
        vectors++;
        if ({output_addr, vector_len, vector_b_addr, vector_a_addr} !== '0) begin
            miscompares++;
            $display("FAIL %s addr: got %h want 0", nm,
                     {output_addr, vector_len, vector_b_addr, vector_a_addr});
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        r0v = 1; r1v = 1; #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset tie_ready: got %b want 01", {req1_ready, req0_ready});
        end
        r0v = 0; r1v = 0; #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset idle_ready: got %b want 00", {req1_ready, req0_ready});
        end
        rst = 1;
        model_last = 1; exp_desc = '0; exp_cmpl = '0;
    endtask

    task automatic test_tie;
        q0.push_back(mkjob(mk(32'h1000, 32'h2000, 32'd16, 32'h3000), 2, 2, 2, 0));
        q0.push_back(mkjob(mk(32'h1100, 32'h2100, 32'd4, 32'h3100), 1, 3, 1, 0));
        q1.push_back(mkjob(mk(32'h5000, 32'h6000, 32'd32, 32'h7000), 3, 1, 2, 0));
        run_sched("tie", 200);
    endtask

    task automatic test_single_job;
        q0.push_back(mkjob(mk(32'h100, 32'h200, 32'd8, 32'h300), 3, 3, 3, 0));
        run_sched("single", 100);
    endtask

    task automatic test_bad_len;
        q0.push_back(mkjob(mk(32'hA0, 32'hB0, 32'd0, 32'hC0), 1, 1, 1, 0));
        q0.push_back(mkjob(mk(32'hA1, 32'hB1, 32'(ML + 1), 32'hC1), 1, 1, 1, 0));
        q1.push_back(mkjob(mk(32'hA2, 32'hB2, 32'hFFFF_FFFF, 32'hC2), 1, 1, 1, 0));
        q1.push_back(mkjob(mk(32'hA3, 32'hB3, 32'(ML), 32'hC3), 1, 1, 1, 0));
        run_sched("badlen", 100);
    endtask

    task automatic test_timeout;
        q0.push_back(mkjob(mk(32'h10, 32'h20, 32'd5, 32'h30), 2, 0, 2, 0));
        q0.push_back(mkjob(mk(32'h11, 32'h21, 32'd6, 32'h31), 0, 1, 1, 0));
        q0.push_back(mkjob(mk(32'h12, 32'h22, 32'd7, 32'h32), 1, 1, TMO + 1, 0));
        q0.push_back(mkjob(mk(32'h13, 32'h23, 32'd9, 32'h33), 1, TMO, 1, 0));
        run_sched("timeout", 300);
    endtask

    task automatic test_stale;
        q1.push_back(mkjob(mk(32'h40, 32'h50, 32'd12, 32'h60), 4, 3, 2, 1));
        q0.push_back(mkjob(mk(32'h41, 32'h51, 32'd13, 32'h61), 1, 1, 1, 1));
        run_sched("stale", 100);
    endtask

    task automatic test_reset_midjob;
        int n;
        n = 0;
        cur_df = 1; cur_dc = 0; cur_dw = 1; cur_stale = 0;
        @(posedge clk); #3;
        r0d = mk(32'hDEAD0, 32'hBEEF0, 32'd20, 32'hCAFE0);
        r0v = 1; #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst accept_ready: got %b want 1", req0_ready);
        end
        @(posedge clk); #3;
        r0v = 0;
        while (start_compute !== 1'b1 && n < 20) begin
            @(posedge clk); #3; n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL midrst start_compute: got none within 20 cycles want pulse");
        end
        repeat (2) begin @(posedge clk); #3; end
        vectors++;
        if ({busy, cmpl_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst waitc: got busy/cv=%b want 10", {busy, cmpl_valid});
        end
        rst = 0; #1;
        check_reset_outputs("midrst");
        r1v = 1; #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst idle_ready: got %b want 10", {req1_ready, req0_ready});
        end
        r1v = 0;
        @(posedge clk); #3;
        check_reset_outputs("midrst_hold");
        rst = 1;
        model_last = 1; exp_desc = '0; exp_cmpl = '0;
        q0.push_back(mkjob(mk(32'h700, 32'h800, 32'd64, 32'h900), 1, 2, 1, 0));
        q1.push_back(mkjob(mk(32'h701, 32'h801, 32'd65, 32'h901), 2, 1, 3, 0));
        run_sched("after_rst", 100);
    endtask

    function automatic int rnd_delay();
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) return 0;
        if (k == 1) return TMO;
        return $urandom_range(1, 4);
    endfunction

    task automatic test_random;
        job_t j;
        int   k;
        logic [LW-1:0] len;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)      len = '0;
            else if (k == 1) len = 32'(ML + 1) + 32'($urandom_range(0, 1000));
            else if (k == 2) len = 32'(ML);
            else             len = 32'($urandom_range(1, ML));
            j = mkjob(mk($urandom, $urandom, len, $urandom), rnd_delay(), rnd_delay(),
                      rnd_delay(), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) q1.push_back(j);
            else                           q0.push_back(j);
        end
        run_sched("random", 3000);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_job();
        test_bad_len();
        test_timeout();
        test_stale();
        test_reset_midjob();
        test_random();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end by 400000ns want earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
